spi_master_ctrl: RTL

- Sequences one complete SPI transaction against the SPI memory slave (shift register, address latch, data memory) on behalf of a local requester.
- A single start pulse runs the whole transaction:
  - drives chip select;
  - generates sclk from the system clock;
  - serialises the address/rw byte, then turnaround pulses, then the data byte;
  - for a read, captures the returned byte.
- Sits between local control logic and the cs_pin/sclk_pin/mosi_pin/miso_pin pads.

---
 rtl/spi_master_ctrl.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/spi_master_ctrl.sv
// SPI mode-0 master: runs one address/rw byte, turnaround pulses and a data byte
// per start request, capturing the returned byte on reads.
module spi_master_ctrl #(
  parameter int unsigned width      = 8,
  parameter int unsigned addr_width = 7,
  parameter int unsigned clk_div    = 2,
  parameter int unsigned gap_cycles = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  rw,
  input  logic [addr_width-1:0] addr,
  input  logic [width-1:0]      wdata,
  output logic                  busy,
  output logic                  done,
  output logic [width-1:0]      rdata,
  output logic                  cs_pin,
  output logic                  sclk_pin,
  output logic                  mosi_pin,
  input  logic                  miso_pin
);

  localparam int unsigned AbW  = addr_width + 1;
  localparam int unsigned DivW = (clk_div > 1) ? $clog2(clk_div) : 1;
  localparam int unsigned MaxA = (AbW > width) ? AbW : width;
  localparam int unsigned MaxN = (gap_cycles > MaxA) ? gap_cycles : MaxA;
  localparam int unsigned CntW = $clog2(MaxN);

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StAddr,
    StTurn,
    StData,
    StHold,
    StDone
  } state_e;

  state_e          state_q, state_d;
  logic [DivW-1:0] div_q, div_d;
  logic            phase_q, phase_d;  // 0: low half of a pulse, 1: high half
  logic [CntW-1:0] bit_q, bit_d;
  logic [AbW-2:0]  tx_q, tx_d;        // address-byte bits still to go after the current one
  logic [width-1:0] wdata_q, wdata_d;
  logic            rw_q, rw_d;
  logic [width-1:0] rx_q, rx_d;
  logic [width-1:0] rdata_q, rdata_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            cs_q, cs_d;
  logic            sclk_q, sclk_d;
  logic            mosi_q, mosi_d;

  logic tick;
  logic pulse_last;

  assign tick = (div_q == DivW'(clk_div - 1));

  assign pulse_last = (state_q == StAddr) ? (bit_q == CntW'(AbW - 1)) :
                      (state_q == StTurn) ? (bit_q == CntW'(gap_cycles - 1)) :
                                            (bit_q == CntW'(width - 1));

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    phase_d = phase_q;
    bit_d   = bit_q;
    tx_d    = tx_q;
    wdata_d = wdata_q;
    rw_d    = rw_q;
    rx_d    = rx_q;
    rdata_d = rdata_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    cs_d    = cs_q;
    sclk_d  = sclk_q;
    mosi_d  = mosi_q;

    case (state_q)
      StIdle: begin
        div_d  = '0;
        busy_d = 1'b0;
        cs_d   = 1'b1;
        sclk_d = 1'b0;
        mosi_d = 1'b0;
        if (start) begin
          state_d = StSetup;
          tx_d    = {addr[addr_width-2:0], rw};
          wdata_d = wdata;
          rw_d    = rw;
          phase_d = 1'b0;
          bit_d   = '0;
          busy_d  = 1'b1;
          cs_d    = 1'b0;
          mosi_d  = addr[addr_width-1];
        end
      end

      StSetup: begin
        div_d = tick ? '0 : div_q + DivW'(1);
        if (tick) state_d = StAddr;
      end

      StAddr, StTurn, StData: begin
        div_d = tick ? '0 : div_q + DivW'(1);
        if (tick) begin
          if (!phase_q) begin
            // Rising sclk edge: this is also where the slave's bit is sampled.
            phase_d = 1'b1;
            sclk_d  = 1'b1;
            if (state_q == StData && rw_q) rx_d = {rx_q[width-2:0], miso_pin};
          end else begin
            phase_d = 1'b0;
            sclk_d  = 1'b0;
            if (!pulse_last) begin
              bit_d = bit_q + CntW'(1);
              if (state_q == StAddr) begin
                mosi_d = tx_q[AbW-2];
                tx_d   = {tx_q[AbW-3:0], 1'b0};
              end else if (state_q == StTurn) begin
                mosi_d = 1'b0;
              end else begin
                mosi_d  = ~rw_q & wdata_q[width-2];
                wdata_d = {wdata_q[width-2:0], 1'b0};
              end
            end else begin
              bit_d = '0;
              if (state_q == StAddr && gap_cycles > 0) begin
                state_d = StTurn;
                mosi_d  = 1'b0;
              end else if (state_q != StData) begin
                state_d = StData;
                mosi_d  = ~rw_q & wdata_q[width-1];
              end else begin
                state_d = StHold;
                mosi_d  = 1'b0;
              end
            end
          end
        end
      end

      StHold: begin
        div_d = tick ? '0 : div_q + DivW'(1);
        if (tick) begin
          state_d = StDone;
          cs_d    = 1'b1;
          done_d  = 1'b1;
          if (rw_q) rdata_d = rx_q;
        end
      end

      StDone: begin
        state_d = StIdle;
        div_d   = '0;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      div_q   <= '0;
      phase_q <= 1'b0;
      bit_q   <= '0;
      tx_q    <= '0;
      wdata_q <= '0;
      rw_q    <= 1'b0;
      rx_q    <= '0;
      rdata_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cs_q    <= 1'b1;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      phase_q <= phase_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
      wdata_q <= wdata_d;
      rw_q    <= rw_d;
      rx_q    <= rx_d;
      rdata_q <= rdata_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cs_q    <= cs_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign rdata    = rdata_q;
  assign cs_pin   = cs_q;
  assign sclk_pin = sclk_q;
  assign mosi_pin = mosi_q;

endmodule
